// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the arbitrated ALU block:
//   - default operand/result width and opcode width
//   - ALU opcode encodings
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_OPW   = 3;

  // Opcodes decoded by the ALU. The codes 3'b110 and 3'b111 are not
  // decoded and produce a zero result.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational ALU datapath owned by alu_arbiter.
// Ports:
//   i_a, i_b    operands (i_b ignored by OP_NOT)
//   i_opcode    operation select (see alu_pkg)
//   o_result    WIDTH-bit result, wraps modulo 2^WIDTH, no carry-out
//   o_zero      high when o_result is all zeros
// ---------------------------------------------------------------------------
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OPW-1:0]   i_opcode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_result
    // unassigned; otherwise synthesis infers a latch.
    o_result = '0;
    case (i_opcode)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOT:  o_result = ~i_a;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters with round-robin arbitration.
// An accepted operation is registered, executed for one cycle, and its
// result is returned on a valid/ready response channel tagged with the
// requester id. One operation is in flight at a time.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_reqN_valid/o_reqN_ready requester N handshake (ready is combinational)
//   i_reqN_a/b/op            requester N operands and opcode
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_result/zero/id     response payload
//   o_busy                   high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [OPW-1:0]   i_req0_op,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [OPW-1:0]   i_req1_op,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zero,
  output logic             o_rsp_id,
  output logic             o_busy
);

  state_t           r_state;
  logic             r_rr_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_id;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_idle;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zero;

  // A lone requester always wins; on contention r_rr_ptr picks the winner.
  assign w_grant0 = i_req0_valid & (~i_req1_valid | (r_rr_ptr == 1'b0));
  assign w_grant1 = i_req1_valid & (~i_req0_valid | (r_rr_ptr == 1'b1));
  assign w_idle   = (r_state == S_IDLE);

  assign o_req0_ready = w_idle & w_grant0;
  assign o_req1_ready = w_idle & w_grant1;

  // Any encoding other than IDLE (including the unused one) counts as busy.
  assign o_busy = ~w_idle;

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_opcode (r_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples values from before the edge, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_a     <= w_grant1 ? i_req1_a  : i_req0_a;
            r_b     <= w_grant1 ? i_req1_b  : i_req0_b;
            r_op    <= w_grant1 ? i_req1_op : i_req0_op;
            r_id    <= w_grant1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_result <= w_alu_result;
          r_rsp_zero   <= w_alu_zero;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          // Payload registers are untouched here, so they hold while stalled.
          if (r_rsp_valid & i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= ~r_rsp_id;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized transactions, all compared against a behavioural model of
// the arbitration order and the ALU arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_req0_valid, i_req1_valid;
  logic       o_req0_ready, o_req1_ready;
  logic [3:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [2:0] i_req0_op, i_req1_op;
  logic       o_rsp_valid, i_rsp_ready;
  logic [3:0] o_rsp_result;
  logic       o_rsp_zero, o_rsp_id, o_busy;

  int n_checks = 0;
  int n_errors = 0;
  bit m_rr     = 1'b0;  // requester that wins the next contended grant

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req0_op    (i_req0_op),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .i_req1_op    (i_req1_op),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_result (o_rsp_result),
    .o_rsp_zero   (o_rsp_zero),
    .o_rsp_id     (o_rsp_id),
    .o_busy       (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: plain integer arithmetic reduced modulo 16.
  function automatic logic [3:0] model_alu(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    case (op)
      3'd0:    r = (ia + ib) % 16;
      3'd1:    r = (ia - ib + 16) % 16;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      3'd5:    r = 15 - ia;
      default: r = 0;
    endcase
    return 4'(r);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'(0));
    check({tag, ".busy"}, 32'(o_busy), 32'(0));
  endtask

  // One full transaction: present requests, accept, execute, optionally
  // stall the response for 'stall' cycles, then complete the handshake.
  // The losing requester keeps its valid asserted throughout.
  task automatic run_txn(input string tag, input bit v0, input bit v1,
                         input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                         input int stall);
    bit         win;
    logic [3:0] er;
    logic [3:0] held_res;
    win = (v0 && v1) ? m_rr : v1;
    er  = win ? model_alu(op1, a1, b1) : model_alu(op0, a0, b0);

    i_req0_valid = v0; i_req0_a = a0; i_req0_b = b0; i_req0_op = op0;
    i_req1_valid = v1; i_req1_a = a1; i_req1_b = b1; i_req1_op = op1;
    i_rsp_ready  = 1'b0;
    #1;
    check({tag, ".grant0"}, 32'(o_req0_ready), 32'(v0 && !win));
    check({tag, ".grant1"}, 32'(o_req1_ready), 32'(v1 && win));
    check({tag, ".idle_busy"}, 32'(o_busy), 32'(0));

    tick();  // accept edge
    // The winner withdraws and scrambles its bus; the latched copy must be used.
    if (win) begin
      i_req1_valid = 1'b0; i_req1_a = ~a1; i_req1_b = ~b1; i_req1_op = ~op1;
    end else begin
      i_req0_valid = 1'b0; i_req0_a = ~a0; i_req0_b = ~b0; i_req0_op = ~op0;
    end
    #1;
    check({tag, ".exec_valid"}, 32'(o_rsp_valid), 32'(0));
    check({tag, ".exec_busy"}, 32'(o_busy), 32'(1));
    check({tag, ".exec_rdy"}, 32'({o_req0_ready, o_req1_ready}), 32'(0));

    tick();  // execute edge: response becomes valid
    check({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'(1));
    check({tag, ".result"}, 32'(o_rsp_result), 32'(er));
    check({tag, ".zero"}, 32'(o_rsp_zero), 32'(er == 4'd0));
    check({tag, ".id"}, 32'(o_rsp_id), 32'(win));
    held_res = er;

    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, ".stall_valid"}, 32'(o_rsp_valid), 32'(1));
      check({tag, ".stall_result"}, 32'(o_rsp_result), 32'(held_res));
      check({tag, ".stall_id"}, 32'(o_rsp_id), 32'(win));
      check({tag, ".stall_rdy"}, 32'({o_req0_ready, o_req1_ready}), 32'(0));
      check({tag, ".stall_busy"}, 32'(o_busy), 32'(1));
    end

    i_rsp_ready = 1'b1;
    tick();  // handshake edge
    i_rsp_ready = 1'b0;
    check_idle_outputs({tag, ".done"});
    m_rr = ~win;
  endtask

  initial begin
    logic [3:0] ra0, rb0, ra1, rb1;
    logic [2:0] rop0, rop1;
    logic [1:0] rv;

    rst_n        = 1'b0;
    i_req0_valid = 1'b0; i_req0_a = '0; i_req0_b = '0; i_req0_op = '0;
    i_req1_valid = 1'b0; i_req1_a = '0; i_req1_b = '0; i_req1_op = '0;
    i_rsp_ready  = 1'b0;
    #12;

    // Reset values.
    check("rst.rsp_valid", 32'(o_rsp_valid), 32'(0));
    check("rst.result", 32'(o_rsp_result), 32'(0));
    check("rst.zero", 32'(o_rsp_zero), 32'(0));
    check("rst.id", 32'(o_rsp_id), 32'(0));
    check("rst.busy", 32'(o_busy), 32'(0));
    check("rst.rdy_none", 32'({o_req0_ready, o_req1_ready}), 32'(0));
    // Pointer resets to requester 0.
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    #1;
    check("rst.rr_ptr", 32'({o_req0_ready, o_req1_ready}), 32'(2'b10));
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_rr = 1'b0;

    // Round-robin under continuous contention: 0, then 1, then 0.
    run_txn("rr_a", 1, 1, 4'd1, 4'd2, 3'b000, 4'd6, 4'd2, 3'b001, 0);
    run_txn("rr_b", 1, 1, 4'd1, 4'd2, 3'b000, 4'd6, 4'd2, 3'b001, 0);
    run_txn("rr_c", 1, 1, 4'd9, 4'd3, 3'b010, 4'd9, 4'd3, 3'b011, 0);

    // Single requesters and arithmetic corner cases.
    run_txn("add0", 1, 0, 4'b0101, 4'b0011, 3'b000, 4'd0, 4'd0, 3'b000, 0);
    run_txn("sub_zero", 0, 1, 4'd0, 4'd0, 3'b000, 4'b0101, 4'b0101, 3'b001, 0);
    run_txn("add_wrap", 1, 0, 4'b1111, 4'b0001, 3'b000, 4'd0, 4'd0, 3'b000, 0);
    run_txn("not", 1, 0, 4'b1010, 4'b1111, 3'b101, 4'd0, 4'd0, 3'b000, 0);
    run_txn("undecoded", 0, 1, 4'd0, 4'd0, 3'b000, 4'd7, 4'd3, 3'b111, 0);

    // Stalled response with the other requester waiting.
    run_txn("stall5", 1, 1, 4'd3, 4'd4, 3'b100, 4'd12, 4'd5, 3'b011, 5);

    // Valid withdrawn before a clock edge: no grant.
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    tick();
    i_req0_valid = 1'b1;
    #1;
    check("drop.ready", 32'(o_req0_ready), 32'(1));
    i_req0_valid = 1'b0;
    tick();
    check_idle_outputs("drop");

    // Reset while executing.
    i_req0_valid = 1'b1; i_req0_a = 4'd5; i_req0_b = 4'd1; i_req0_op = 3'b000;
    tick();  // accepted
    i_req0_valid = 1'b0;
    check("rst_exec.busy_before", 32'(o_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    m_rr  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle_outputs("rst_exec.after");
    end

    // Reset while holding a response: payload clears at once.
    i_req1_valid = 1'b1; i_req1_a = 4'd3; i_req1_b = 4'd4; i_req1_op = 3'b000;
    tick();
    i_req1_valid = 1'b0;
    tick();
    check("rst_resp.result_before", 32'(o_rsp_result), 32'(7));
    rst_n = 1'b0;
    #1;
    check("rst_resp.valid", 32'(o_rsp_valid), 32'(0));
    check("rst_resp.result", 32'(o_rsp_result), 32'(0));
    check("rst_resp.id", 32'(o_rsp_id), 32'(0));
    check("rst_resp.busy", 32'(o_busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_rr  = 1'b0;
    tick();

    // Contention right after reset goes to requester 0 again.
    run_txn("post_rst", 1, 1, 4'd2, 4'd2, 3'b000, 4'd1, 4'd1, 3'b000, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      rv   = 2'($urandom_range(1, 3));
      ra0  = 4'($urandom); rb0 = 4'($urandom); rop0 = 3'($urandom);
      ra1  = 4'($urandom); rb1 = 4'($urandom); rop1 = 3'($urandom);
      run_txn($sformatf("rand%0d", t), rv[0], rv[1], ra0, rb0, rop0, ra1, rb1, rop1,
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
